cbfp_sf_reader: RTL and testbench



---
 rtl/cbfp_pkg.sv | 49 ++++
 rtl/cbfp_lane_scale.sv | 26 ++
 rtl/cbfp_sf_reader.sv | 136 +++++++++++++
 tb/tb_cbfp_sf_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared CBFP definitions: widths, scale-factor types, reader states and the
// common shift/saturate helper used by both CBFP stages.
package cbfp_pkg;

    localparam int unsigned FACTOR_WIDTH = 5;
    localparam int unsigned NUM_LANES    = 16;
    localparam int unsigned BEATS        = 2;
    localparam int unsigned SF_COUNT     = NUM_LANES * BEATS;
    localparam int unsigned IN_WIDTH     = 16;
    localparam int unsigned OUT_WIDTH    = 13;
    localparam int unsigned BLK_WIDTH    = 16;

    // Sum of two factors needs one extra bit; a shift never exceeds IN_WIDTH-1.
    localparam int unsigned TOT_WIDTH    = FACTOR_WIDTH + 1;
    localparam int unsigned SHIFT_WIDTH  = $clog2(IN_WIDTH);
    localparam int unsigned BEAT_WIDTH   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [FACTOR_WIDTH-1:0]               sf_t;
    typedef sf_t [SF_COUNT-1:0]                    sf_vec_t;
    typedef sf_t [NUM_LANES-1:0]                   sf_lane_vec_t;
    typedef logic signed [IN_WIDTH-1:0]            in_sample_t;
    typedef logic signed [OUT_WIDTH-1:0]           out_sample_t;
    typedef logic [NUM_LANES-1:0][IN_WIDTH-1:0]    in_vec_t;
    typedef logic [NUM_LANES-1:0][OUT_WIDTH-1:0]   out_vec_t;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } rd_state_t;

    // Output range expressed at input width so the comparison stays signed.
    localparam in_sample_t OUT_MAX = in_sample_t'(IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1));
    localparam in_sample_t OUT_MIN = ~OUT_MAX;

    // Arithmetic (floor) right shift followed by saturation to OUT_WIDTH.
    function automatic out_sample_t sat_shift(input in_sample_t x,
                                              input logic [SHIFT_WIDTH-1:0] s);
        in_sample_t y;
        y = x >>> s;
        if (y > OUT_MAX) begin
            sat_shift = OUT_MAX[OUT_WIDTH-1:0];
        end else if (y < OUT_MIN) begin
            sat_shift = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat_shift = y[OUT_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/cbfp_lane_scale.sv
// One lane component: add the two block factors, clamp the shift amount,
// then shift and saturate the sample. Purely combinational.
module cbfp_lane_scale
    import cbfp_pkg::*;
(
    input  sf_t         sf1,
    input  sf_t         sf2,
    input  in_sample_t  x,
    output out_sample_t y_c
);

    logic [TOT_WIDTH-1:0]   tot_c;
    logic [SHIFT_WIDTH-1:0] shift_c;

    // Shifts past IN_WIDTH-1 would only replicate the sign, so clamp there.
    always_comb begin
        tot_c = TOT_WIDTH'(sf1) + TOT_WIDTH'(sf2);
        if (tot_c > TOT_WIDTH'(IN_WIDTH - 1)) begin
            shift_c = SHIFT_WIDTH'(IN_WIDTH - 1);
        end else begin
            shift_c = tot_c[SHIFT_WIDTH-1:0];
        end
        y_c = sat_shift(x, shift_c);
    end

endmodule

// File: rtl/cbfp_sf_reader.sv
// Consumer side of the stage-1 scale-factor buffer: pops one factor vector per
// block, applies stage-1 + stage-2 factors to each beat, registers the result.
module cbfp_sf_reader
    import cbfp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sf_avail,
    output logic                 pop,
    input  sf_vec_t              sc_fac_cbfp1,
    input  logic                 din_valid,
    output logic                 in_ready,
    input  in_vec_t              din_re,
    input  in_vec_t              din_im,
    input  sf_lane_vec_t         sf2,
    output logic                 dout_valid,
    output out_vec_t             dout_re,
    output out_vec_t             dout_im,
    output logic [BLK_WIDTH-1:0] blk_cnt,
    output logic                 underrun_err
);

    rd_state_t              state_q, state_d;
    logic [BEAT_WIDTH-1:0]  beat_q, beat_d;
    logic [BLK_WIDTH-1:0]   blk_q, blk_d;
    logic                   accept_c;
    sf_lane_vec_t           sf1_sel_c;
    out_vec_t               scaled_re_c;
    out_vec_t               scaled_im_c;

    // State, beat and block counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            beat_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
        end
    end

    // Next state, pop and ready. A refill pop coincides with the last-beat
    // accept so the next block starts with no bubble.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        blk_d    = blk_q;
        pop      = 1'b0;
        in_ready = 1'b0;
        accept_c = 1'b0;
        case (state_q)
            EMPTY: begin
                if (sf_avail) begin
                    pop     = 1'b1;
                    state_d = LOADED;
                end
            end
            LOADED: begin
                in_ready = 1'b1;
                accept_c = din_valid;
                if (accept_c) begin
                    if (beat_q == BEAT_WIDTH'(BEATS - 1)) begin
                        beat_d = '0;
                        blk_d  = blk_q + 1'b1;
                        if (sf_avail) begin
                            pop = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Select this beat's slice of the stage-1 factor vector.
    always_comb begin
        sf1_sel_c = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_WIDTH'(b)) begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    sf1_sel_c[i] = sc_fac_cbfp1[b * NUM_LANES + i];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        cbfp_lane_scale u_re (
            .sf1 (sf1_sel_c[i]),
            .sf2 (sf2[i]),
            .x   (din_re[i]),
            .y_c (scaled_re_c[i])
        );
        cbfp_lane_scale u_im (
            .sf1 (sf1_sel_c[i]),
            .sf2 (sf2[i]),
            .x   (din_im[i]),
            .y_c (scaled_im_c[i])
        );
    end

    // Output register; data holds between accepted beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
        end else begin
            dout_valid <= accept_c;
            if (accept_c) begin
                dout_re <= scaled_re_c;
                dout_im <= scaled_im_c;
            end
        end
    end

    // Sticky flag for beats offered while no factor vector is held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underrun_err <= 1'b0;
        end else if (din_valid && !in_ready) begin
            underrun_err <= 1'b1;
        end
    end

    assign blk_cnt = blk_q;

endmodule

// File: tb/tb_cbfp_sf_reader.sv
// Bench for cbfp_sf_reader: table of per-block vectors plus hand-written
// sequences, with a queue of expected output beats checked as they appear.
module tb_cbfp_sf_reader;
    import cbfp_pkg::*;

    logic         clk;
    logic         rstn;
    logic         sf_avail;
    logic         pop;
    sf_vec_t      sc_fac;
    sf_vec_t      next_vec;
    logic         din_valid;
    logic         in_ready;
    in_vec_t      din_re;
    in_vec_t      din_im;
    sf_lane_vec_t sf2;
    logic         dout_valid;
    out_vec_t     dout_re;
    out_vec_t     dout_im;
    logic [15:0]  blk_cnt;
    logic         underrun_err;

    typedef struct {
        logic [4:0]         sf1;
        logic [4:0]         sf2;
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic [12:0]        er;
        logic [12:0]        ei;
    } row_t;

    typedef struct {
        out_vec_t re;
        out_vec_t im;
        int       due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    out_vec_t    last_re;
    out_vec_t    last_im;
    row_t        rows[8];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    int          beat_idx = 0;
    bit          use_tbl = 0;
    logic [12:0] tbl_er;
    logic [12:0] tbl_ei;
    logic [15:0] base_blk;

    cbfp_sf_reader dut (
        .clk          (clk),
        .rstn         (rstn),
        .sf_avail     (sf_avail),
        .pop          (pop),
        .sc_fac_cbfp1 (sc_fac),
        .din_valid    (din_valid),
        .in_ready     (in_ready),
        .din_re       (din_re),
        .din_im       (din_im),
        .sf2          (sf2),
        .dout_valid   (dout_valid),
        .dout_re      (dout_re),
        .dout_im      (dout_im),
        .blk_cnt      (blk_cnt),
        .underrun_err (underrun_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Factor buffer: a pop presents the next vector from the following cycle.
    always @(posedge clk) if (pop === 1'b1) sc_fac <= next_vec;

    // Reference: floor division by 2^s, then clamp to the 13-bit range.
    function automatic logic [12:0] ref_scale(input logic signed [15:0] x,
                                              input logic [4:0] a, input logic [4:0] b);
        int t, s, p, v;
        t = int'(a) + int'(b);
        s = (t > 15) ? 15 : t;
        p = 1 << s;
        v = int'(x);
        if (v >= 0) v = v / p;
        else        v = -((-v + p - 1) / p);
        if (v > 4095)  v = 4095;
        if (v < -4096) v = -4096;
        return 13'(v);
    endfunction

    function automatic row_t mk_row(input int a, input int b, input int re, input int im,
                                    input int er, input int ei);
        row_t r;
        r.sf1 = 5'(a);
        r.sf2 = 5'(b);
        r.re  = 16'(re);
        r.im  = 16'(im);
        r.er  = 13'(er);
        r.ei  = 13'(ei);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // One cycle: check handshake, queue the expected beat, advance to next negedge.
    task automatic step(input bit exp_rdy, input bit exp_pop);
        exp_t e;
        #1;
        checks++;
        if (in_ready !== exp_rdy || pop !== exp_pop) begin
            errors++;
            $display("FAIL handshake cyc=%0d in_ready=%b pop=%b required in_ready=%b pop=%b",
                     cyc, in_ready, pop, exp_rdy, exp_pop);
        end
        if (pop === 1'b1) pop_cnt++;
        if (din_valid && exp_rdy) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (use_tbl) begin
                    e.re[i] = tbl_er;
                    e.im[i] = tbl_ei;
                end else begin
                    e.re[i] = ref_scale(din_re[i], sc_fac[beat_idx * int'(NUM_LANES) + i], sf2[i]);
                    e.im[i] = ref_scale(din_im[i], sc_fac[beat_idx * int'(NUM_LANES) + i], sf2[i]);
                end
            end
            e.due = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Two beats with per-lane constant data; sf_avail flips mid-block on purpose.
    task automatic run_block(input logic [15:0] re, input logic [15:0] im, input bit avail_end);
        din_valid = 1'b1;
        din_re    = {NUM_LANES{re}};
        din_im    = {NUM_LANES{im}};
        beat_idx  = 0;
        sf_avail  = ~avail_end;
        step(1'b1, 1'b0);
        beat_idx  = 1;
        sf_avail  = avail_end;
        step(1'b1, avail_end);
        din_valid = 1'b0;
        sf_avail  = 1'b0;
    endtask

    // Output scoreboard: every valid beat must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dout_spurious cyc=%0d got dout_valid=1 required 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                last_re = mon_e.re;
                last_im = mon_e.im;
                if (dout_re !== mon_e.re || dout_im !== mon_e.im || mon_e.due != cyc) begin
                    errors++;
                    $display("FAIL dout cyc=%0d due=%0d re=%h req_re=%h im=%h req_im=%h",
                             cyc, mon_e.due, dout_re, mon_e.re, dout_im, mon_e.im);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL dout_missing cyc=%0d got dout_valid=0 required 1 (due %0d)", cyc, mon_e.due);
        end
    end

    initial begin
        rows[0] = mk_row(3, 2, 1000, -1000, 31, -32);
        rows[1] = mk_row(0, 0, 20000, -20000, 4095, -4096);
        rows[2] = mk_row(20, 20, 20000, -20000, 0, -1);
        rows[3] = mk_row(1, 0, -1, 1, -1, 0);
        rows[4] = mk_row(2, 2, -32768, 32767, -2048, 2047);
        rows[5] = mk_row(0, 0, -4097, 4096, -4096, 4095);
        rows[6] = mk_row(7, 0, -129, 127, -2, 0);
        rows[7] = mk_row(31, 31, -32768, 32767, -1, 0);

        rstn      = 1'b0;
        sf_avail  = 1'b0;
        din_valid = 1'b0;
        din_re    = '0;
        din_im    = '0;
        sf2       = '0;
        next_vec  = '0;
        sc_fac    = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", longint'({pop, in_ready, dout_valid, underrun_err,
                                       |dout_re, |dout_im, |blk_cnt}), 0);
        rstn = 1'b1;

        // Table: one block per row, FSM returns to EMPTY between rows.
        use_tbl = 1'b1;
        for (int r = 0; r < 8; r++) begin
            next_vec = {SF_COUNT{rows[r].sf1}};
            sf2      = {NUM_LANES{rows[r].sf2}};
            tbl_er   = rows[r].er;
            tbl_ei   = rows[r].ei;
            sf_avail = 1'b1;
            step(1'b0, 1'b1);
            if (r == 0) chk("blk_cnt_first_load", longint'(blk_cnt), 0);
            run_block(rows[r].re, rows[r].im, 1'b0);
            chk("blk_cnt_table", longint'(blk_cnt), longint'(r + 1));
            step(1'b0, 1'b0);
        end
        use_tbl = 1'b0;

        // Factor indexing: beat b lane i must use entry b*16+i.
        for (int pat = 0; pat < 2; pat++) begin
            for (int k = 0; k < int'(SF_COUNT); k++) next_vec[k] = (pat == 0) ? 5'(k % 8) : 5'(k / 2);
            sf2      = '0;
            sf_avail = 1'b1;
            step(1'b0, 1'b1);
            run_block(16'h4000, 16'hC000, 1'b0);
            step(1'b0, 1'b0);
        end

        // Back-to-back: four blocks, refill pop on each last beat except the final one.
        base_blk = blk_cnt;
        pop_cnt  = 0;
        for (int k = 0; k < int'(SF_COUNT); k++) next_vec[k] = 5'($urandom);
        sf_avail = 1'b1;
        step(1'b0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            for (int bt = 0; bt < 2; bt++) begin
                din_valid = 1'b1;
                for (int i = 0; i < int'(NUM_LANES); i++) begin
                    din_re[i] = 16'($urandom);
                    din_im[i] = 16'($urandom);
                    sf2[i]    = 5'($urandom);
                end
                beat_idx = bt;
                if (bt == 0) begin
                    sf_avail = 1'b1;
                    step(1'b1, 1'b0);
                    for (int k = 0; k < int'(SF_COUNT); k++) next_vec[k] = 5'($urandom);
                end else begin
                    sf_avail = (b < 3);
                    step(1'b1, b < 3);
                end
            end
        end
        din_valid = 1'b0;
        sf_avail  = 1'b0;
        step(1'b0, 1'b0);
        chk("b2b_pop_count", longint'(pop_cnt), 4);
        chk("b2b_blk_cnt", longint'(blk_cnt), longint'(base_blk) + 4);

        // Underrun: beat offered in EMPTY is flagged and dropped.
        chk("underrun_clear", longint'(underrun_err), 0);
        din_valid = 1'b1;
        step(1'b0, 1'b0);
        din_valid = 1'b0;
        step(1'b0, 1'b0);
        chk("underrun_set", longint'(underrun_err), 1);
        chk("underrun_no_dout", longint'(dout_valid), 0);
        checks++;
        if (dout_re !== last_re || dout_im !== last_im) begin
            errors++;
            $display("FAIL dout_hold cyc=%0d re=%h req_re=%h", cyc, dout_re, last_re);
        end

        // Reset in the middle of a block.
        for (int k = 0; k < int'(SF_COUNT); k++) next_vec[k] = 5'($urandom);
        sf_avail = 1'b1;
        step(1'b0, 1'b1);
        sf_avail  = 1'b0;
        din_valid = 1'b1;
        din_re    = {NUM_LANES{16'h1234}};
        din_im    = {NUM_LANES{16'hEDCB}};
        beat_idx  = 0;
        step(1'b1, 1'b0);
        #2;
        rstn      = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("midreset_outputs", longint'({pop, in_ready, dout_valid, underrun_err,
                                          |dout_re, |dout_im, |blk_cnt}), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Fresh block after reset must start at beat 0 and take two beats.
        for (int k = 0; k < int'(SF_COUNT); k++) next_vec[k] = 5'($urandom);
        sf2      = {NUM_LANES{5'd1}};
        sf_avail = 1'b1;
        step(1'b0, 1'b1);
        run_block(16'h7FFF, 16'h8000, 1'b0);
        chk("post_reset_blk_cnt", longint'(blk_cnt), 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("queue_drained", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
